// File: rtl/trace_capture_fifo.sv
// Trace capture FIFO: buffers the core's instruction trace stream, counts overflow drops,
// and stops capturing on trap, then drains and raises capture_done.
module trace_capture_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_LOG2 = 6,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  trap,
    input  logic                  trace_valid,
    input  logic [WIDTH-1:0]      trace_data,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  capture_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    localparam logic [1:0] S_CAPTURE = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]            state;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  empty;
    logic                  accepting;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level     = wr_ptr - rd_ptr;
    assign accepting = (state == S_CAPTURE);

    // Head word is driven as zero while empty so the port never shows uninitialised storage.
    assign out_valid    = !empty && (state != S_DONE);
    assign out_data     = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign capture_done = (state == S_DONE);

    assign pop  = out_valid && out_ready;
    assign push = trace_valid && accepting && (!full || pop);
    assign drop = trace_valid && accepting && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= trace_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // DRAIN finishes when occupancy after this edge's pop is zero (no pushes in DRAIN).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_CAPTURE;
        end else begin
            case (state)
                S_CAPTURE: if (trap) state <= S_DRAIN;
                S_DRAIN:   if (empty || (level == PTR_ONE && pop)) state <= S_DONE;
                S_DONE:    state <= S_DONE;
                default:   state <= S_CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Randomised and directed bench for trace_capture_fifo: a queue-based reference model
// predicts accepted words and status; a negedge monitor pops and compares.
module tb_trace_capture_fifo;

    localparam int WIDTH = 36;
    localparam int DL    = 6;
    localparam int CNT_W = 4;
    localparam int DEPTH = 64;
    localparam int CMAX  = 15;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              trap = 1'b0;
    logic              trace_valid = 1'b0;
    logic [WIDTH-1:0]  trace_data = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [DL:0]       level;
    logic              full;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;
    logic              capture_done;

    trace_capture_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .trap         (trap),
        .trace_valid  (trace_valid),
        .trace_data   (trace_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: current state (m_*) and prediction for after the next edge (n_*).
    logic [WIDTH-1:0] exp_q[$];
    int m_level, n_level;
    int m_drop,  n_drop;
    bit m_capt,  n_capt;
    bit m_done,  n_done;
    bit m_ovf,   n_ovf;
    logic [WIDTH-1:0] last_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0; m_drop = 0; m_capt = 1'b1; m_done = 1'b0; m_ovf = 1'b0;
        n_level = 0; n_drop = 0; n_capt = 1'b1; n_done = 1'b0; n_ovf = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict the edge, wait for it, commit the prediction.
    task automatic cycle(input bit tv, input logic [WIDTH-1:0] d, input bit rdy, input bit tr);
        bit ov, pp, ps, dr;
        trace_valid = tv;
        trace_data  = d;
        out_ready   = rdy;
        trap        = tr;
        ov = (m_level > 0) && !m_done;
        pp = ov && rdy;
        ps = tv && m_capt && ((m_level < DEPTH) || pp);
        dr = tv && m_capt && (m_level == DEPTH) && !pp;
        if (ps) exp_q.push_back(d);
        n_level = m_level + int'(ps) - int'(pp);
        n_ovf   = m_ovf || dr;
        n_drop  = dr ? ((m_drop < CMAX) ? m_drop + 1 : CMAX) : m_drop;
        n_capt  = m_capt;
        n_done  = m_done;
        if (m_capt && tr) n_capt = 1'b0;
        else if (!m_capt && !m_done && n_level == 0) n_done = 1'b1;
        @(posedge clk);
        #1;
        m_level = n_level; m_ovf = n_ovf; m_drop = n_drop; m_capt = n_capt; m_done = n_done;
    endtask

    task automatic idle_drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; caller checks outputs before release.
    task automatic assert_reset();
        #2;
        resetn = 1'b0;
        trace_valid = 1'b0; out_ready = 1'b0; trap = 1'b0; trace_data = '0;
        #1;
    endtask

    task automatic release_reset();
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("out_valid", 64'(out_valid), 64'((m_level > 0) && !m_done));
            chk("level", 64'(level), 64'(m_level));
            chk("full", 64'(full), 64'(m_level == DEPTH));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            chk("capture_done", 64'(capture_done), 64'(m_done));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_pop: got %0h expected no word at %0t", out_data, $time);
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                    last_out = out_data;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_capture_done", 64'(capture_done), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Three words in order, one-cycle fall-through latency.
        cycle(1'b1, 36'h000000001, 1'b1, 1'b0);
        chk("t1_first_valid", 64'(out_valid), 64'd1);
        cycle(1'b1, 36'h000000002, 1'b1, 1'b0);
        cycle(1'b1, 36'h000000003, 1'b1, 1'b0);
        idle_drain(4);
        chk("t1_level_zero", 64'(level), 64'd0);

        // Overflow: 70 pushes with no consumer.
        for (int i = 0; i < 70; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_drop_count", 64'(drop_count), 64'd6);
        chk("t2_overflow", 64'(overflow), 64'd1);
        idle_drain(66);

        // Full FIFO with simultaneous push and pop never drops.
        for (int i = 0; i < 64; i++) cycle(1'b1, WIDTH'(36'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'(36'h200 + i), 1'b1, 1'b0);
        chk("t3_level", 64'(level), 64'd64);
        chk("t3_drop_count", 64'(drop_count), 64'd6);
        idle_drain(66);

        // Random traffic with varying consumer throttle.
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct;
            rdy_pct = 10 + 25 * (blk % 4);
            for (int i = 0; i < 100; i++)
                cycle(($urandom % 4) != 0, {$urandom, $urandom} % (64'd1 << WIDTH),
                      ($urandom % 100) < rdy_pct, 1'b0);
        end
        idle_drain(66);

        // Trap together with the final trace word.
        cycle(1'b1, 36'h000000111, 1'b0, 1'b0);
        cycle(1'b1, 36'h000000222, 1'b0, 1'b0);
        cycle(1'b1, 36'hABCDE1234, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(36'h333 + i), 1'b0, 1'b0);
        chk("t4_level_after_trap", 64'(level), 64'd3);
        k = 0;
        while (!capture_done && k < 100) begin
            cycle(1'b1, 36'h444, 1'b1, 1'b0);
            k++;
        end
        chk("t4_capture_done", 64'(capture_done), 64'd1);
        chk("t4_last_word", 64'(last_out), 64'hABCDE1234);
        for (int i = 0; i < 4; i++) cycle(1'b1, 36'h555, 1'b1, i[0]);
        chk("t4_done_sticky", 64'(capture_done), 64'd1);

        assert_reset();
        release_reset();

        // Drop counter saturation.
        for (int i = 0; i < 64; i++) cycle(1'b1, WIDTH'(36'h600 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'(36'h700 + i), 1'b0, 1'b0);
        chk("t5_drop_sat", 64'(drop_count), 64'(CMAX));
        cycle(1'b1, 36'h7FF, 1'b0, 1'b0);
        chk("t5_drop_hold", 64'(drop_count), 64'(CMAX));

        // Async reset while draining with ten words left.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 54; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t6_level_pre", 64'(level), 64'd10);
        assert_reset();
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_capture_done", 64'(capture_done), 64'd0);
        chk("t6_drop_count", 64'(drop_count), 64'd0);
        release_reset();
        for (int i = 0; i < 300; i++)
            cycle(($urandom % 3) != 0, {$urandom, $urandom} % (64'd1 << WIDTH),
                  ($urandom % 2) == 0, 1'b0);
        idle_drain(66);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
